bridge_car_counter: RTL and testbench

- Parametrised successor to the drawbridge car counter.
- Tracks how many vehicles are on the bridge deck using multiple entry and exit lane sensors.
- Counts each vehicle once per sensor rising edge, saturates at a configurable capacity, and flags overflow/underflow faults.
- Exposes occupancy state to the drawbridge controller, which must not raise the deck unless the bridge is empty.

---
 rtl/bridge_pkg.sv | 15 +
 rtl/lane_edge_detect.sv | 29 ++
 rtl/bridge_car_counter.sv | 115 +++++++++++
 tb/tb_bridge_car_counter.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/bridge_pkg.sv
// rtl/bridge_pkg.sv - shared bridge occupancy constants and state encodings
package bridge_pkg;

    localparam int DEF_LANES    = 2;
    localparam int DEF_CNT_W    = 4;
    localparam int DEF_MAX_CARS = 10;

    typedef enum logic [1:0] {
        ST_EMPTY    = 2'd0,
        ST_OCCUPIED = 2'd1,
        ST_FULL     = 2'd2,
        ST_FAULT    = 2'd3
    } bridge_state_e;

endpackage

// File: rtl/lane_edge_detect.sv
// rtl/lane_edge_detect.sv - per-lane rising-edge detector for sensor levels
module lane_edge_detect #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] sensor,
    output logic [W-1:0] rise
);

    logic [W-1:0] prev_q;
    logic [W-1:0] prev_d;

    always_comb begin
        prev_d = sensor;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= '0;
        end else begin
            prev_q <= prev_d;
        end
    end

    // prev clears on reset, so a sensor already high at release counts once
    assign rise = sensor & ~prev_q;

endmodule

// File: rtl/bridge_car_counter.sv
// rtl/bridge_car_counter.sv - multi-lane bridge deck occupancy counter
// Entries and exits net out before saturating; faults are sticky until cleared.
module bridge_car_counter
    import bridge_pkg::*;
#(
    parameter int LANES    = DEF_LANES,
    parameter int CNT_W    = DEF_CNT_W,
    parameter int MAX_CARS = DEF_MAX_CARS
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [LANES-1:0] CarIn,
    input  logic [LANES-1:0] CarOut,
    input  logic             ClearFault,
    output logic [CNT_W-1:0] CarCount,
    output logic             ExistCar,
    output logic             Full,
    output logic             Overflow,
    output logic             Underflow,
    output logic [1:0]       State
);

    // Wide enough for count + LANES entries and count - LANES exits, plus sign
    localparam int TW = CNT_W + $clog2(LANES) + 2;
    localparam logic signed [TW-1:0] MAX_T    = TW'(MAX_CARS);
    localparam logic [CNT_W-1:0]     MAX_CNT  = CNT_W'(MAX_CARS);

    logic [LANES-1:0] in_rise;
    logic [LANES-1:0] out_rise;

    lane_edge_detect #(.W(LANES)) u_in_edge (
        .clk    (Clk),
        .rst_n  (Reset),
        .sensor (CarIn),
        .rise   (in_rise)
    );

    lane_edge_detect #(.W(LANES)) u_out_edge (
        .clk    (Clk),
        .rst_n  (Reset),
        .sensor (CarOut),
        .rise   (out_rise)
    );

    logic [CNT_W-1:0]       count_q, count_d;
    logic                   ovf_q, ovf_d;
    logic                   unf_q, unf_d;
    bridge_state_e          state_q, state_d;

    logic [TW-1:0]          nin, nout;
    logic signed [TW-1:0]   t;
    logic                   ovf_event, unf_event;

    always_comb begin
        nin  = '0;
        nout = '0;
        for (int i = 0; i < LANES; i++) begin
            nin  = nin  + {{(TW-1){1'b0}}, in_rise[i]};
            nout = nout + {{(TW-1){1'b0}}, out_rise[i]};
        end
        t = $signed({{(TW-CNT_W){1'b0}}, count_q} + nin - nout);
    end

    always_comb begin
        count_d   = count_q;
        ovf_event = 1'b0;
        unf_event = 1'b0;
        if (t[TW-1]) begin
            count_d   = '0;
            unf_event = 1'b1;
        end else if (t > MAX_T) begin
            count_d   = MAX_CNT;
            ovf_event = 1'b1;
        end else begin
            count_d   = t[CNT_W-1:0];
        end

        // A fault raised in the clearing cycle wins over the clear
        ovf_d = (ovf_q & ~ClearFault) | ovf_event;
        unf_d = (unf_q & ~ClearFault) | unf_event;
    end

    always_comb begin
        state_d = ST_OCCUPIED;
        if (ovf_d || unf_d) begin
            state_d = ST_FAULT;
        end else if (count_d == '0) begin
            state_d = ST_EMPTY;
        end else if (count_d == MAX_CNT) begin
            state_d = ST_FULL;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            state_q <= ST_EMPTY;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            state_q <= state_d;
        end
    end

    assign CarCount  = count_q;
    assign ExistCar  = |count_q;
    assign Full      = (count_q == MAX_CNT);
    assign Overflow  = ovf_q;
    assign Underflow = unf_q;
    assign State     = state_q;

endmodule

// File: tb/tb_bridge_car_counter.sv
// tb/tb_bridge_car_counter.sv - directed and random checks against an occupancy model
module tb_bridge_car_counter;

    localparam int LANES    = 2;
    localparam int CNT_W    = 4;
    localparam int MAX_CARS = 10;

    logic             Clk;
    logic             Reset;
    logic [LANES-1:0] CarIn;
    logic [LANES-1:0] CarOut;
    logic             ClearFault;
    logic [CNT_W-1:0] CarCount;
    logic             ExistCar;
    logic             Full;
    logic             Overflow;
    logic             Underflow;
    logic [1:0]       State;

    bridge_car_counter #(
        .LANES    (LANES),
        .CNT_W    (CNT_W),
        .MAX_CARS (MAX_CARS)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .CarIn      (CarIn),
        .CarOut     (CarOut),
        .ClearFault (ClearFault),
        .CarCount   (CarCount),
        .ExistCar   (ExistCar),
        .Full       (Full),
        .Overflow   (Overflow),
        .Underflow  (Underflow),
        .State      (State)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_pass   = 0;

    int             m_cnt;
    bit             m_ovf;
    bit             m_unf;
    int             m_state;
    bit [LANES-1:0] m_pin;
    bit [LANES-1:0] m_pout;

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    endtask

    task automatic m_reset();
        m_cnt = 0; m_ovf = 0; m_unf = 0; m_state = 0;
        m_pin = '0; m_pout = '0;
    endtask

    task automatic m_edge(input bit [LANES-1:0] cin, input bit [LANES-1:0] cout, input bit clr);
        int nin, nout, t;
        bit oe, ue;
        nin = 0; nout = 0; oe = 0; ue = 0;
        for (int i = 0; i < LANES; i++) begin
            if (cin[i] && !m_pin[i])   nin++;
            if (cout[i] && !m_pout[i]) nout++;
        end
        m_pin = cin; m_pout = cout;
        t = m_cnt + nin - nout;
        if (t > MAX_CARS)  begin m_cnt = MAX_CARS; oe = 1; end
        else if (t < 0)    begin m_cnt = 0; ue = 1; end
        else               m_cnt = t;
        if (clr) begin m_ovf = 0; m_unf = 0; end
        if (oe) m_ovf = 1;
        if (ue) m_unf = 1;
        if (m_ovf || m_unf)        m_state = 3;
        else if (m_cnt == 0)       m_state = 0;
        else if (m_cnt == MAX_CARS) m_state = 2;
        else                       m_state = 1;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".cnt"},   int'(CarCount),  m_cnt);
        check({tag, ".exist"}, int'(ExistCar),  int'(m_cnt != 0));
        check({tag, ".full"},  int'(Full),      int'(m_cnt == MAX_CARS));
        check({tag, ".ovf"},   int'(Overflow),  int'(m_ovf));
        check({tag, ".unf"},   int'(Underflow), int'(m_unf));
        check({tag, ".state"}, int'(State),     m_state);
    endtask

    task automatic step(input string tag, input logic [LANES-1:0] cin,
                        input logic [LANES-1:0] cout, input logic clr);
        CarIn = cin; CarOut = cout; ClearFault = clr;
        @(posedge Clk);
        m_edge(cin, cout, clr);
        #1;
        check_all(tag);
    endtask

    initial begin
        Reset = 1'b0; CarIn = '0; CarOut = '0; ClearFault = 1'b0;
        m_reset();
        repeat (2) @(posedge Clk);
        #1;
        check_all("reset");
        @(negedge Clk);
        Reset = 1'b1;

        // Held sensor counts once
        step("hold0", 2'b01, 2'b00, 0);
        check("hold_first", int'(CarCount), 1);
        step("hold1", 2'b01, 2'b00, 0);
        step("hold2", 2'b01, 2'b00, 0);
        step("drop",  2'b00, 2'b00, 0);
        check("hold_state", int'(State), 1);

        // Two lanes in one edge, then a single exit
        step("dual",  2'b11, 2'b00, 0);
        check("dual_cnt", int'(CarCount), 3);
        step("dual0", 2'b00, 2'b00, 0);
        step("exit",  2'b00, 2'b10, 0);
        check("exit_cnt", int'(CarCount), 2);
        step("exit0", 2'b00, 2'b00, 0);

        // Fill to capacity, overflow, clear back to FULL
        for (int i = 0; i < 4; i++) begin
            step("fill", 2'b11, 2'b00, 0);
            step("fill0", 2'b00, 2'b00, 0);
        end
        check("full_cnt", int'(CarCount), MAX_CARS);
        step("ovf",  2'b01, 2'b00, 0);
        check("ovf_flag", int'(Overflow), 1);
        step("ovf0", 2'b00, 2'b00, 0);
        step("clr",  2'b00, 2'b00, 1);
        check("clr_state", int'(State), 2);

        // Simultaneous in/out at capacity nets to no change
        step("net_full", 2'b01, 2'b01, 0);
        step("net0",     2'b00, 2'b00, 0);

        // Drain to empty
        for (int i = 0; i < 5; i++) begin
            step("drain",  2'b00, 2'b11, 0);
            step("drain0", 2'b00, 2'b00, 0);
        end
        step("net_empty", 2'b01, 2'b01, 0);
        step("net0b",     2'b00, 2'b00, 0);

        // Underflow, then clear in the same cycle as another exit
        step("unf",    2'b00, 2'b01, 0);
        check("unf_flag", int'(Underflow), 1);
        step("unf0",   2'b00, 2'b00, 0);
        step("unfclr", 2'b00, 2'b01, 1);
        check("unf_sticky", int'(Underflow), 1);
        step("unf1",   2'b00, 2'b00, 1);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic [LANES-1:0] ri, ro;
            logic rc;
            ri = LANES'($urandom);
            ro = LANES'($urandom);
            rc = ($urandom_range(0, 7) == 0);
            step("rand", ri, ro, rc);
        end

        // Walk to 5 cars, then reset asynchronously between edges
        step("pre", 2'b00, 2'b00, 1);
        for (int i = 0; i < 40 && m_cnt != 5; i++) begin
            if (m_cnt < 5) step("to5", 2'b01, 2'b00, 1);
            else           step("to5", 2'b00, 2'b01, 1);
            step("to5z", 2'b00, 2'b00, 1);
        end
        check("reach5", int'(CarCount), 5);
        #2;
        Reset = 1'b0;
        CarIn = 2'b01;
        #1;
        m_reset();
        check_all("async_rst");
        @(negedge Clk);
        Reset = 1'b1;
        step("rst_rel", 2'b01, 2'b00, 0);
        check("rst_rel_cnt", int'(CarCount), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
